// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter
//
// Purpose:
//   Shares one SRAM-like request port between the instruction-fetch port (I)
//   and the data port (D). Request selection is combinational. D has priority,
//   but a starvation guard forces a grant to I after STARVE_LIMIT consecutive
//   D grants while I was waiting. An in-order ID FIFO records the owner of each
//   accepted transaction, so that every returned data_ok/rdata is steered back
//   to the port that issued it.
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   i_*/d_* req,wr,size,wstrb,addr,wdata   requests from the I and D ports
//   i_addr_ok / d_addr_ok            request accepted this cycle
//   i_data_ok / d_data_ok            completion pulse for that port
//   i_rdata / d_rdata                read data, a copy of s_rdata
//   s_req,wr,size,wstrb,addr,wdata   shared request to the bridge
//   s_addr_ok, s_data_ok, s_rdata    bridge handshake and read data
//   protocol_err                     sticky flag: completion seen with no
//                                    transaction outstanding
module sram_like_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned DEPTH        = 4
) (
    input  logic        clk,
    input  logic        reset,
    // fetch port
    input  logic        i_req,
    input  logic        i_wr,
    input  logic [1:0]  i_size,
    input  logic [3:0]  i_wstrb,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    // data port
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [1:0]  d_size,
    input  logic [3:0]  d_wstrb,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    // shared port to the bridge
    output logic        s_req,
    output logic        s_wr,
    output logic [1:0]  s_size,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_addr_ok,
    input  logic        s_data_ok,
    input  logic [31:0] s_rdata,
    output logic        protocol_err
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_LIMIT) + 1;

    // ID FIFO storage: 0 = I, 1 = D
    logic [DEPTH-1:0] r_ids;
    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [StW-1:0]   r_starve;
    logic             r_perr;

    logic w_grant_i;
    logic w_full;
    logic w_accept;
    logic w_push;
    logic w_pop;
    logic w_head;
    logic w_starved;

    assign w_starved = (r_starve == StW'(STARVE_LIMIT));
    assign w_full    = (r_count == CntW'(DEPTH));

    // D wins ties unless I has been starved; with no request the mux rests on D.
    assign w_grant_i = i_req && (!d_req || w_starved);

    always_comb begin
        s_req   = (w_grant_i ? i_req : d_req) && !w_full;
        s_wr    = d_wr;
        s_size  = d_size;
        s_wstrb = d_wstrb;
        s_addr  = d_addr;
        s_wdata = d_wdata;
        if (w_grant_i) begin
            s_wr    = i_wr;
            s_size  = i_size;
            s_wstrb = i_wstrb;
            s_addr  = i_addr;
            s_wdata = i_wdata;
        end
    end

    assign w_accept  = s_req && s_addr_ok;
    assign i_addr_ok = w_accept && w_grant_i;
    assign d_addr_ok = w_accept && !w_grant_i;

    assign w_push = w_accept;
    // A completion with nothing outstanding pops nothing; it only flags an error.
    assign w_pop  = s_data_ok && (r_count != '0);
    assign w_head = r_ids[r_rd_ptr];

    assign i_data_ok    = w_pop && !w_head;
    assign d_data_ok    = w_pop && w_head;
    assign i_rdata      = s_rdata;
    assign d_rdata      = s_rdata;
    assign protocol_err = r_perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ids    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_starve <= '0;
            r_perr   <= 1'b0;
        end else begin
            if (w_push) begin
                r_ids[r_wr_ptr] <= !w_grant_i;
                r_wr_ptr        <= r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase

            if (i_addr_ok || !i_req) begin
                r_starve <= '0;
            end else if (d_addr_ok && !w_starved) begin
                r_starve <= r_starve + StW'(1);
            end

            if (s_data_ok && (r_count == '0)) begin
                r_perr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Testbench for sram_like_arbiter: a per-cycle reference model with an
// expected-ID scoreboard queue, plus directed sequences for grant order,
// ordering, full, spurious return and mid-flight reset.
module tb_sram_like_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned DEPTH        = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size;
    logic [3:0]  i_wstrb, d_wstrb;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        s_req, s_wr;
    logic [1:0]  s_size;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_addr_ok, s_data_ok;
    logic [31:0] s_rdata;
    logic        protocol_err;

    sram_like_arbiter #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .DEPTH        (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_wr         (i_wr),
        .i_size       (i_size),
        .i_wstrb      (i_wstrb),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .i_addr_ok    (i_addr_ok),
        .i_data_ok    (i_data_ok),
        .i_rdata      (i_rdata),
        .d_req        (d_req),
        .d_wr         (d_wr),
        .d_size       (d_size),
        .d_wstrb      (d_wstrb),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_addr_ok    (d_addr_ok),
        .d_data_ok    (d_data_ok),
        .d_rdata      (d_rdata),
        .s_req        (s_req),
        .s_wr         (s_wr),
        .s_size       (s_size),
        .s_wstrb      (s_wstrb),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_addr_ok    (s_addr_ok),
        .s_data_ok    (s_data_ok),
        .s_rdata      (s_rdata),
        .protocol_err (protocol_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Scoreboard: owner ID of each accepted transaction, 0 = I, 1 = D.
    bit exp_q[$];
    bit grants[$];
    int m_starve = 0;
    bit m_perr   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, expv);
    endtask

    task automatic idle_inputs();
        i_req = 0; i_wr = 0; i_size = 0; i_wstrb = 0; i_addr = 0; i_wdata = 0;
        d_req = 0; d_wr = 0; d_size = 0; d_wstrb = 0; d_addr = 0; d_wdata = 0;
        s_addr_ok = 0; s_data_ok = 0; s_rdata = 0;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_starve = 0;
        m_perr   = 1'b0;
    endtask

    // One clock of stimulus, with outputs checked against the model mid-cycle.
    task automatic cyc(input bit ireq, input bit iwr, input logic [31:0] iaddr,
                       input bit dreq, input bit dwr, input logic [31:0] daddr,
                       input bit aok, input bit dok, input logic [31:0] rdata);
        bit g_i, full, sreq, acc, pop, head;
        @(negedge clk);
        i_req = ireq; i_wr = iwr; i_addr = iaddr; i_size = 2'd2;
        i_wstrb = iwr ? 4'hf : 4'h0; i_wdata = iaddr ^ 32'h5a5a_0000;
        d_req = dreq; d_wr = dwr; d_addr = daddr; d_size = 2'd1;
        d_wstrb = dwr ? 4'h3 : 4'h0; d_wdata = ~daddr;
        s_addr_ok = aok; s_data_ok = dok; s_rdata = rdata;
        #2;
        g_i  = ireq && (!dreq || m_starve == STARVE_LIMIT);
        full = (exp_q.size() == DEPTH);
        sreq = (g_i ? ireq : dreq) && !full;
        acc  = sreq && aok;
        pop  = dok && (exp_q.size() != 0);
        head = pop ? exp_q[0] : 1'b0;
        check("s_req", 32'(s_req), 32'(sreq));
        check("s_addr", s_addr, g_i ? iaddr : daddr);
        check("s_wdata", s_wdata, g_i ? (iaddr ^ 32'h5a5a_0000) : ~daddr);
        check("s_wr", 32'(s_wr), 32'(g_i ? iwr : dwr));
        check("s_size", 32'(s_size), g_i ? 32'd2 : 32'd1);
        check("i_addr_ok", 32'(i_addr_ok), 32'(acc && g_i));
        check("d_addr_ok", 32'(d_addr_ok), 32'(acc && !g_i));
        check("i_data_ok", 32'(i_data_ok), 32'(pop && !head));
        check("d_data_ok", 32'(d_data_ok), 32'(pop && head));
        if (pop) begin
            check("i_rdata", i_rdata, rdata);
            check("d_rdata", d_rdata, rdata);
        end
        check("protocol_err", 32'(protocol_err), 32'(m_perr));
        if (i_addr_ok || d_addr_ok) grants.push_back(d_addr_ok);
        // advance model to the next cycle
        if (dok && exp_q.size() == 0) m_perr = 1'b1;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(!g_i);
        if ((acc && g_i) || !ireq) m_starve = 0;
        else if (acc && m_starve < STARVE_LIMIT) m_starve++;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 16) begin
            cyc(0, 0, 0, 0, 0, 32'h0, 0, 1, 32'hd000_0000 + guard);
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        bit order_exp [6];
        order_exp = '{1, 1, 1, 1, 0, 1};
        reset = 1'b1;
        idle_inputs();
        do_reset(2);

        // reset state: outputs idle, mux follows d_*
        cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0);

        // single I read
        cyc(1, 0, 32'hbfc0_0000, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3c08_0001);

        // contention: expect D,D,D,D,I,D
        grants.delete();
        for (int k = 0; k < 6; k++) begin
            cyc(1, 0, 32'h1000 + k, 1, 0, 32'h2000 + k, 1, exp_q.size() != 0, 32'ha000 + k);
        end
        check("grant_count", 32'(grants.size()), 32'd6);
        for (int k = 0; k < 6; k++) begin
            if (k < grants.size()) check($sformatf("grant_%0d", k), 32'(grants[k]), 32'(order_exp[k]));
        end
        drain();

        // ordering I, D, I
        cyc(1, 0, 32'h100, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 1, 1, 32'h200, 1, 0, 0);
        cyc(1, 0, 32'h104, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h1111_1111);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h2222_2222);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h3333_3333);

        // full: four accepts, fifth blocked, pop cycle blocked, then accept
        for (int k = 0; k < 4; k++) begin
            cyc(k[0], 0, 32'h300 + k, !k[0], 0, 32'h400 + k, 1, 0, 0);
        end
        cyc(1, 0, 32'h500, 0, 0, 0, 1, 0, 0);
        check("full_blocked", 32'(i_addr_ok), 32'd0);
        cyc(1, 0, 32'h504, 0, 0, 0, 1, 1, 32'h4444_4444);
        check("full_pop_no_accept", 32'(i_addr_ok), 32'd0);
        cyc(1, 0, 32'h508, 0, 0, 0, 1, 0, 0);
        check("after_pop_accept", 32'(i_addr_ok), 32'd1);
        drain();

        // spurious return
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'hdead_beef);
        repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("perr_sticky", 32'(protocol_err), 32'd1);

        // reset with two outstanding
        cyc(0, 0, 0, 1, 0, 32'h600, 1, 0, 0);
        cyc(1, 0, 32'h700, 0, 0, 0, 1, 0, 0);
        do_reset(1);
        cyc(0, 0, 0, 0, 0, 32'h0, 0, 0, 0);
        check("perr_cleared", 32'(protocol_err), 32'd0);
        cyc(1, 0, 32'h800, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_5555);
        check("post_reset_i_data_ok", 32'(i_data_ok), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
